// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and widths, also imported by the decode stage.
// Holds the FSM state encoding and the PC increment helper.
package instr_fetch_pkg;

  localparam int INSTRW = 16;
  localparam int ADDRW  = 16;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // Sequential PC step; wraps from all-ones back to zero.
  function automatic logic [ADDRW-1:0] pc_inc(input logic [ADDRW-1:0] pc);
    return pc + {{(ADDRW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-side
// instruction handshake and control feedback (halt / branch).
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int IW = INSTRW,
  parameter int AW = ADDRW
);

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;

  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;

  logic          halt;
  logic          branch;
  logic [AW-1:0] branch_target;
  logic          halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output instr, instr_pc, instr_valid,
    input  instr_ready,
    input  halt, branch, branch_target,
    output halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  instr, instr_pc, instr_valid,
    output instr_ready,
    output halt, branch, branch_target,
    input  halted
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, single-outstanding-request memory FSM and
// the registered instruction presented to decode with valid/ready.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [ADDRW-1:0] RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  fetch_state_t      state_p0, state_d;
  logic [ADDRW-1:0]  pc_p0, pc_d;
  logic              drop_p0, drop_d;
  logic [INSTRW-1:0] instr_p0, instr_d;
  logic [ADDRW-1:0]  instr_pc_p0, instr_pc_d;
  logic              vld_p0, vld_d;
  logic              req_c;
  logic              req_live;

  // Priority inside every state: halt, then branch, then normal progress.
  always_comb begin
    state_d    = state_p0;
    pc_d       = pc_p0;
    drop_d     = drop_p0;
    instr_d    = instr_p0;
    instr_pc_d = instr_pc_p0;
    vld_d      = vld_p0;
    req_c      = 1'b0;

    case (state_p0)
      REQ: begin
        req_c = 1'b1;
        if (bus.halt) begin
          state_d = HALTED;
          vld_d   = 1'b0;
          drop_d  = 1'b0;
        end else if (bus.branch) begin
          // The request going out this cycle is for the old PC; mark it stale.
          pc_d    = bus.branch_target;
          vld_d   = 1'b0;
          drop_d  = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (bus.halt) begin
          state_d = HALTED;
          vld_d   = 1'b0;
          drop_d  = 1'b0;
        end else if (bus.branch) begin
          pc_d  = bus.branch_target;
          vld_d = 1'b0;
          if (bus.imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (drop_p0) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_p0;
            vld_d      = 1'b1;
            pc_d       = pc_inc(pc_p0);
            state_d    = HOLD;
          end
        end
      end

      HOLD: begin
        if (bus.halt) begin
          state_d = HALTED;
          vld_d   = 1'b0;
        end else if (bus.branch) begin
          pc_d    = bus.branch_target;
          vld_d   = 1'b0;
          state_d = REQ;
        end else if (bus.instr_ready) begin
          // Accept and immediately request the next word in the same cycle.
          req_c   = 1'b1;
          vld_d   = 1'b0;
          state_d = WAIT;
        end
      end

      HALTED: begin
        vld_d = 1'b0;
      end

      default: begin
        state_d = REQ;
        vld_d   = 1'b0;
        drop_d  = 1'b0;
      end
    endcase
  end

  // State / PC / presented instruction registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0    <= REQ;
      pc_p0       <= RST_PC;
      drop_p0     <= 1'b0;
      instr_p0    <= '0;
      instr_pc_p0 <= '0;
      vld_p0      <= 1'b0;
    end else begin
      state_p0    <= state_d;
      pc_p0       <= pc_d;
      drop_p0     <= drop_d;
      instr_p0    <= instr_d;
      instr_pc_p0 <= instr_pc_d;
      vld_p0      <= vld_d;
    end
  end

  // No request may escape while reset is held, even though the state is REQ.
  assign req_live        = req_c & rst_n;
  assign bus.imem_req    = req_live;
  assign bus.imem_addr   = req_live ? pc_p0 : '0;
  assign bus.instr       = instr_p0;
  assign bus.instr_pc    = instr_pc_p0;
  assign bus.instr_valid = vld_p0;
  assign bus.halted      = (state_p0 == HALTED);

endmodule
